uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable data width, optional parity,
// one or two stop bits, delivering each word on a valid/ready handshake with status flags.
module uart_rx_param #(
    parameter int DATA_BITS     = 8,
    parameter int CLKS_PER_TICK = 2,
    parameter int OVERSAMPLE    = 4,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_TICK - 1);
    localparam logic [TW-1:0] T_MID     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [TW-1:0]          t_cnt_q, t_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   overrun_q, overrun_d;

    logic rx_s;
    logic tick;
    logic sample;
    logic bit_end;
    logic complete;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign tick    = (clk_cnt_q == CLK_LAST);
    assign sample  = tick && (t_cnt_q == T_MID);
    assign bit_end = tick && (t_cnt_q == T_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            clk_cnt_q  <= '0;
            t_cnt_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            clk_cnt_q  <= clk_cnt_d;
            t_cnt_q    <= t_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            armed_q    <= armed_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        clk_cnt_d  = '0;
        t_cnt_d    = '0;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        complete   = 1'b0;

        // Counters idle at zero so the tick phase restarts from the start-bit edge.
        if (state_q != S_IDLE) begin
            clk_cnt_d = tick ? '0 : clk_cnt_q + 1'b1;
            t_cnt_d   = t_cnt_q;
            if (tick) begin
                t_cnt_d = (t_cnt_q == T_LAST) ? '0 : t_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                // A start is only armed after the line has been seen high, so a held break never retriggers.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d    = 1'b0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (sample && rx_s) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (bit_end && (bit_cnt_q == BITS_LAST)) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_acc_d = (PARITY == 2) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        ferr_acc_d = 1'b1;
                    end
                    if (stop_cnt_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        // A consumer taking the old word in the completion cycle frees the slot for the new one.
        if (complete) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_acc_q | ~rx_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: one 8N1 instance and one 8E1 instance,
// table-driven frames plus hand-written break, glitch, overrun and reset sequences.
module tb_uart_rx_param;

    localparam int CPT   = 2;
    localparam int OS    = 4;
    localparam int BIT   = CPT * OS;
    localparam int SYNC  = 2;
    // Start edge to valid: sync flops, idle detect, nine whole bits, half of the stop bit.
    localparam int LAT   = SYNC + 1 + 9 * BIT + (OS / 2) * CPT;
    localparam int LAT_P = LAT + BIT;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         which;
        logic [7:0] din;
        bit         has_par;
        logic       par_bit;
        logic       stop_lvl;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_a, rx_p, ready_a, ready_p;
    logic [7:0] data_a, data_p;
    logic       valid_a, valid_p, perr_a, perr_p, ferr_a, ferr_p;
    logic       overrun_a, overrun_p, busy_a, busy_p;

    exp_t sb_q[$];
    vec_t vecs[9];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc_a = 0, rise_cnt_a = 0, rise_cyc_p = 0;
    int ovr_cycles = 0, ovr_cyc = 0;
    logic valid_a_prev = 1'b0, valid_p_prev = 1'b0;

    uart_rx_param dut_a (
        .clock(clock), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
        .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(overrun_a),
        .busy(busy_a)
    );

    uart_rx_param #(.PARITY(1)) dut_p (
        .clock(clock), .reset(reset), .rx(rx_p), .data(data_p), .valid(valid_p),
        .ready(ready_p), .parity_err(perr_p), .frame_err(ferr_p), .overrun(overrun_p),
        .busy(busy_p)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid_a && !valid_a_prev) begin
            rise_cyc_a = cyc;
            rise_cnt_a = rise_cnt_a + 1;
        end
        if (valid_p && !valid_p_prev) begin
            rise_cyc_p = cyc;
        end
        if (overrun_a) begin
            ovr_cycles = ovr_cycles + 1;
            ovr_cyc    = cyc;
        end
        valid_a_prev = valid_a;
        valid_p_prev = valid_p;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got no end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setRx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else rx_p = v;
    endtask

    task automatic setReady(input int which, input logic v);
        if (which == 0) ready_a = v;
        else ready_p = v;
    endtask

    function automatic logic getValid(input int which);
        return (which == 0) ? valid_a : valid_p;
    endfunction

    function automatic logic [7:0] getData(input int which);
        return (which == 0) ? data_a : data_p;
    endfunction

    function automatic logic getPerr(input int which);
        return (which == 0) ? perr_a : perr_p;
    endfunction

    function automatic logic getFerr(input int which);
        return (which == 0) ? ferr_a : ferr_p;
    endfunction

    // Must be entered just after a falling clock edge; returns on a falling edge.
    task automatic applyStimulus(input int which, input logic [7:0] d, input bit has_par,
                                 input logic par_bit, input logic stop_lvl);
        start_cyc = cyc;
        setRx(which, 1'b0);
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            setRx(which, d[i]);
            repeat (BIT) @(negedge clock);
        end
        if (has_par) begin
            setRx(which, par_bit);
            repeat (BIT) @(negedge clock);
        end
        setRx(which, stop_lvl);
        repeat (BIT) @(negedge clock);
        setRx(which, 1'b1);
        repeat (BIT) @(negedge clock);
    endtask

    task automatic takeWord(input int which, input string name);
        exp_t e;
        for (int k = 0; k < 300 && !getValid(which); k++) @(negedge clock);
        checkOutput({name, " valid"}, getValid(which), 1'b1);
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected a pending word", name);
        end else begin
            e = sb_q.pop_front();
            checkOutput({name, " data"}, getData(which), e.data);
            checkOutput({name, " parity_err"}, getPerr(which), e.perr);
            checkOutput({name, " frame_err"}, getFerr(which), e.ferr);
        end
        setReady(which, 1'b1);
        @(negedge clock);
        setReady(which, 1'b0);
        checkOutput({name, " valid drop"}, getValid(which), 1'b0);
    endtask

    initial begin
        exp_t e;
        int   ovr0;
        int   rc0;
        logic [7:0] partial;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        reset   = 1'b1;
        rx_a    = 1'b1;
        rx_p    = 1'b1;
        ready_a = 1'b0;
        ready_p = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset data", data_a, 8'h00);
        checkOutput("reset valid", valid_a, 1'b0);
        checkOutput("reset busy", busy_a, 1'b0);
        checkOutput("reset parity_err", perr_a, 1'b0);
        checkOutput("reset frame_err", ferr_a, 1'b0);
        checkOutput("reset overrun", overrun_a, 1'b0);
        checkOutput("reset valid 8E1", valid_p, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("idle busy", busy_a, 1'b0);

        for (int i = 0; i < 9; i++) begin
            e.data = vecs[i].exp_data;
            e.perr = vecs[i].exp_perr;
            e.ferr = vecs[i].exp_ferr;
            sb_q.push_back(e);
            applyStimulus(vecs[i].which, vecs[i].din, vecs[i].has_par, vecs[i].par_bit,
                          vecs[i].stop_lvl);
            if (vecs[i].which == 0) checkOutput($sformatf("vec%0d latency", i), rise_cyc_a - start_cyc, LAT);
            else checkOutput($sformatf("vec%0d latency", i), rise_cyc_p - start_cyc, LAT_P);
            takeWord(vecs[i].which, $sformatf("vec%0d", i));
        end

        // Break: one word with frame error, then silence until the line goes high again.
        e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1;
        sb_q.push_back(e);
        rc0 = rise_cnt_a;
        start_cyc = cyc;
        rx_a = 1'b0;
        repeat (40 * BIT) @(negedge clock);
        checkOutput("break word count", rise_cnt_a - rc0, 1);
        checkOutput("break latency", rise_cyc_a - start_cyc, LAT);
        takeWord(0, "break");
        repeat (2 * BIT) @(negedge clock);
        checkOutput("break held busy", busy_a, 1'b0);
        checkOutput("break held valid", valid_a, 1'b0);
        rx_a = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        e.data = 8'h5C; e.perr = 1'b0; e.ferr = 1'b0;
        sb_q.push_back(e);
        applyStimulus(0, 8'h5C, 1'b0, 1'b0, 1'b1);
        takeWord(0, "after break");

        // Short low glitch on an idle line.
        rc0 = rise_cnt_a;
        rx_a = 1'b0;
        repeat (2) @(negedge clock);
        rx_a = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("glitch busy rises", busy_a, 1'b1);
        repeat (6) @(negedge clock);
        checkOutput("glitch busy drops", busy_a, 1'b0);
        checkOutput("glitch valid", valid_a, 1'b0);
        repeat (2 * BIT) @(negedge clock);
        checkOutput("glitch no word", rise_cnt_a - rc0, 0);

        // Two frames with ready low: the second is dropped with a single overrun pulse.
        ovr0 = ovr_cycles;
        e.data = 8'h11; e.perr = 1'b0; e.ferr = 1'b0;
        sb_q.push_back(e);
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
        checkOutput("overrun cycles", ovr_cycles - ovr0, 1);
        checkOutput("overrun timing", ovr_cyc - start_cyc, LAT);
        takeWord(0, "overrun kept");

        // Consumer takes the old word in the very cycle the new one completes.
        ovr0 = ovr_cycles;
        e.data = 8'h33; e.perr = 1'b0; e.ferr = 1'b0;
        sb_q.push_back(e);
        e.data = 8'h44;
        sb_q.push_back(e);
        applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b1);
        fork
            applyStimulus(0, 8'h44, 1'b0, 1'b0, 1'b1);
            begin
                exp_t old;
                repeat (LAT - 1) @(negedge clock);
                old = sb_q.pop_front();
                checkOutput("handoff old valid", valid_a, 1'b1);
                checkOutput("handoff old data", data_a, old.data);
                ready_a = 1'b1;
                @(negedge clock);
                ready_a = 1'b0;
                checkOutput("handoff new valid", valid_a, 1'b1);
            end
        join
        checkOutput("handoff no overrun", ovr_cycles - ovr0, 0);
        takeWord(0, "handoff new");

        // Reset in the middle of the data bits of 0x5A.
        partial = 8'h5A;
        rx_a = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx_a = partial[i];
            repeat (BIT) @(negedge clock);
        end
        repeat (BIT / 2) @(negedge clock);
        checkOutput("mid-frame busy", busy_a, 1'b1);
        reset = 1'b1;
        rx_a  = 1'b1;
        #2;
        checkOutput("mid reset data", data_a, 8'h00);
        checkOutput("mid reset valid", valid_a, 1'b0);
        checkOutput("mid reset busy", busy_a, 1'b0);
        checkOutput("mid reset frame_err", ferr_a, 1'b0);
        checkOutput("mid reset overrun", overrun_a, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clock);
        e.data = 8'h77; e.perr = 1'b0; e.ferr = 1'b0;
        sb_q.push_back(e);
        applyStimulus(0, 8'h77, 1'b0, 1'b0, 1'b1);
        checkOutput("after reset latency", rise_cyc_a - start_cyc, LAT);
        takeWord(0, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
